// File: rtl/gate_truth_table_sequencer_if.sv
// gate_truth_table_sequencer_if
//   Bundles the stimulus/check signals between the truth-table sequencer and its
//   environment (the gate under test plus whoever issues start).
//   Parameter N_IN: number of gate inputs.
//   Signals:
//     start      sequencer input   one-cycle pulse, starts a run from IDLE or DONE
//     y_in       sequencer input   output of the gate under test
//     vec_out    sequencer output  input vector applied to the gate (bit0 -> a, bit1 -> b)
//     vec_idx    sequencer output  index of the vector currently applied
//     busy       sequencer output  run in progress
//     done       sequencer output  run finished, held until next start or rst
//     pass       sequencer output  valid while done; 1 iff err_count == 0
//     err_count  sequencer output  mismatching vectors in the current/last run
//     state      sequencer output  FSM state for observation (IDLE=0, DRIVE=1,
//                                  WAIT=2, SAMPLE=3, DONE=4)
//   Optional (macro FIRST_FAIL_CAPTURE_EN):
//     fail_valid sequencer output  a mismatch has been seen in this run
//     fail_vec   sequencer output  index of the first mismatching vector
//   Modports: master = sequencer side, slave = environment side.
interface gate_truth_table_sequencer_if #(
  parameter int N_IN = 2
);
  logic            start;
  logic            y_in;
  logic [N_IN-1:0] vec_out;
  logic [N_IN-1:0] vec_idx;
  logic            busy;
  logic            done;
  logic            pass;
  logic [N_IN:0]   err_count;
  logic [2:0]      state;
`ifdef FIRST_FAIL_CAPTURE_EN
  logic            fail_valid;
  logic [N_IN-1:0] fail_vec;

  modport master (
    input  start, y_in,
    output vec_out, vec_idx, busy, done, pass, err_count, state,
    output fail_valid, fail_vec
  );
  modport slave (
    output start, y_in,
    input  vec_out, vec_idx, busy, done, pass, err_count, state,
    input  fail_valid, fail_vec
  );
`else
  modport master (
    input  start, y_in,
    output vec_out, vec_idx, busy, done, pass, err_count, state
  );
  modport slave (
    output start, y_in,
    input  vec_out, vec_idx, busy, done, pass, err_count, state
  );
`endif
endinterface

// File: rtl/gate_truth_table_sequencer.sv
// gate_truth_table_sequencer
//   Exhaustive stimulus/check stage for a small combinational gate. Applies every
//   input combination 0 .. 2**N_IN-1 on vec_out, waits SETTLE cycles for the gate
//   to settle, samples y_in and compares it with bit vec_idx of the EXPECT table.
//   At the end of the run it raises done and reports pass and err_count.
// Parameters:
//   N_IN    number of gate inputs (2**N_IN vectors per run)
//   EXPECT  expected-output table, bit i = expected y for vector i (default AND)
//   SETTLE  wait cycles between driving a vector and sampling y_in, 1..255
// Ports:
//   clk  rising-edge clock
//   rst  synchronous active-high reset, has priority over start
//   bus  gate_truth_table_sequencer_if.master (start, y_in in; vec_out, vec_idx,
//        busy, done, pass, err_count, state out)
// Optional feature, macro FIRST_FAIL_CAPTURE_EN:
//   adds fail_valid/fail_vec, which latch the index of the first mismatch of a run.
// Handshake: start is a single-cycle request accepted only in IDLE or DONE; busy
//   rises on the accepting edge and falls on the edge that raises done. A start seen
//   while busy is dropped, never queued. done/pass/err_count stay stable until the
//   next accepted start or rst.
// Timing: each vector occupies DRIVE (1) + WAIT (SETTLE) + SAMPLE (1) cycles, so a
//   run takes 2**N_IN*(SETTLE+2) cycles from the start edge to done.
module gate_truth_table_sequencer #(
  parameter int                  N_IN   = 2,
  parameter logic [2**N_IN-1:0]  EXPECT = 4'b1000,
  parameter int                  SETTLE = 2
) (
  input  logic                           clk,
  input  logic                           rst,
  gate_truth_table_sequencer_if.master   bus
);

  localparam logic [7:0]      SETTLE_CNT = 8'(SETTLE);
  localparam logic [N_IN-1:0] LAST_IDX   = '1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DRIVE  = 3'd1,
    ST_WAIT   = 3'd2,
    ST_SAMPLE = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  state_t          state;
  logic [7:0]      settle_cnt;
  logic [N_IN-1:0] idx;        // drives both vec_out and vec_idx
  logic            busy;
  logic            done;
  logic            pass;
  logic [N_IN:0]   err_count;
  logic            mismatch;
  logic [N_IN:0]   err_next;

  // Only consumed in SAMPLE; y_in is ignored in every other state.
  assign mismatch = (bus.y_in != EXPECT[idx]);
  // Never wraps: at most 2**N_IN mismatches, which fits in N_IN+1 bits.
  assign err_next = err_count + {{N_IN{1'b0}}, mismatch};

`ifdef FIRST_FAIL_CAPTURE_EN
  logic            fail_valid;
  logic [N_IN-1:0] fail_vec;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      settle_cnt <= '0;
      idx        <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      err_count  <= '0;
`ifdef FIRST_FAIL_CAPTURE_EN
      fail_valid <= 1'b0;
      fail_vec   <= '0;
`endif
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (bus.start) begin
            state     <= ST_DRIVE;
            idx       <= '0;
            err_count <= '0;
            busy      <= 1'b1;
            done      <= 1'b0;
            pass      <= 1'b0;
`ifdef FIRST_FAIL_CAPTURE_EN
            fail_valid <= 1'b0;
            fail_vec   <= '0;
`endif
          end
        end
        ST_DRIVE: begin
          settle_cnt <= SETTLE_CNT;
          state      <= ST_WAIT;
        end
        ST_WAIT: begin
          // Leaves on the edge where the count reaches zero, giving exactly
          // SETTLE cycles in WAIT.
          settle_cnt <= settle_cnt - 8'd1;
          if (settle_cnt == 8'd1) begin
            state <= ST_SAMPLE;
          end
        end
        ST_SAMPLE: begin
          err_count <= err_next;
`ifdef FIRST_FAIL_CAPTURE_EN
          if (mismatch && !fail_valid) begin
            fail_valid <= 1'b1;
            fail_vec   <= idx;
          end
`endif
          if (idx == LAST_IDX) begin
            // vec_out keeps the last vector until the next start.
            state <= ST_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (err_next == '0);
          end else begin
            idx   <= idx + N_IN'(1);
            state <= ST_DRIVE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.vec_out   = idx;
  assign bus.vec_idx   = idx;
  assign bus.busy      = busy;
  assign bus.done      = done;
  assign bus.pass      = pass;
  assign bus.err_count = err_count;
  assign bus.state     = state;
`ifdef FIRST_FAIL_CAPTURE_EN
  assign bus.fail_valid = fail_valid;
  assign bus.fail_vec   = fail_vec;
`endif

endmodule

// File: tb/tb_gate_truth_table_sequencer.sv
// tb_gate_truth_table_sequencer
//   Two sequencers share clk/rst/start: dut_a with default parameters (AND table,
//   SETTLE=2) and dut_b with EXPECT=4'b0110, SETTLE=1 (XOR table). Each drives its
//   own gate model selected by 'mode': 0 correct gate, 1 tied 0, 2 tied 1,
//   3 random bit per cycle. A cycle-indexed run model predicts every output.
module tb_gate_truth_table_sequencer;

  logic clk = 1'b0;
  logic rst;
  logic start;
  logic rnd_bit;
  int   mode;
  logic chk_en;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  gate_truth_table_sequencer_if #(.N_IN(2)) if_a ();
  gate_truth_table_sequencer_if #(.N_IN(2)) if_b ();

  assign if_a.start = start;
  assign if_b.start = start;
  assign if_a.y_in  = (mode == 0) ? (&if_a.vec_out) :
                      (mode == 1) ? 1'b0 : (mode == 2) ? 1'b1 : rnd_bit;
  assign if_b.y_in  = (mode == 0) ? (^if_b.vec_out) :
                      (mode == 1) ? 1'b0 : (mode == 2) ? 1'b1 : rnd_bit;

  gate_truth_table_sequencer dut_a (
    .clk (clk),
    .rst (rst),
    .bus (if_a)
  );

  gate_truth_table_sequencer #(
    .N_IN   (2),
    .EXPECT (4'b0110),
    .SETTLE (1)
  ) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (if_b)
  );

  // ---------------- reference model ----------------
  logic [3:0] exp_tab [2] = '{4'b1000, 4'b0110};
  int m_t    [2] = '{-1, -1};   // cycle index within the run, -1 = idle
  int m_err  [2] = '{0, 0};
  int m_fv   [2] = '{0, 0};
  int m_fvec [2] = '{0, 0};

  function automatic int period(input int i);
    return (i == 0) ? 4 : 3;    // SETTLE + 2
  endfunction

  function automatic int run_len(input int i);
    return 4 * period(i);
  endfunction

  function automatic int gate_y(input int i, input int k);
    if (i == 0) return (k == 3) ? 1 : 0;
    return (k == 1 || k == 2) ? 1 : 0;
  endfunction

  function automatic int model_y(input int i, input int k);
    case (mode)
      0:       return gate_y(i, k);
      1:       return 0;
      2:       return 1;
      default: return int'(rnd_bit);
    endcase
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        m_t[i] = -1; m_err[i] = 0; m_fv[i] = 0; m_fvec[i] = 0;
      end else if (m_t[i] >= 0 && m_t[i] < run_len(i)) begin
        // last cycle of each vector slot is the sampling cycle
        if (m_t[i] % period(i) == period(i) - 1) begin
          int k;
          k = m_t[i] / period(i);
          if (model_y(i, k) != int'(exp_tab[i][k])) begin
            m_err[i]++;
            if (m_fv[i] == 0) begin
              m_fv[i] = 1; m_fvec[i] = k;
            end
          end
        end
        m_t[i]++;
      end else if (start) begin
        m_t[i] = 0; m_err[i] = 0; m_fv[i] = 0; m_fvec[i] = 0;
      end
    end
  end

  // ---------------- checking ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  task automatic check_inst(input int i, input logic [1:0] vec, input logic [1:0] vidx,
                            input logic bsy, input logic dn, input logic ps,
                            input logic [2:0] err, input logic fv, input logic [1:0] fvec);
    int ev, eb, ed, ep;
    if (m_t[i] < 0) begin
      ev = 0; eb = 0; ed = 0; ep = 0;
    end else if (m_t[i] < run_len(i)) begin
      ev = m_t[i] / period(i); eb = 1; ed = 0; ep = 0;
    end else begin
      ev = 3; eb = 0; ed = 1; ep = (m_err[i] == 0) ? 1 : 0;
    end
    chk($sformatf("cyc%0d.vec_out", i), 32'(vec), ev);
    chk($sformatf("cyc%0d.vec_idx", i), 32'(vidx), ev);
    chk($sformatf("cyc%0d.busy", i), 32'(bsy), eb);
    chk($sformatf("cyc%0d.done", i), 32'(dn), ed);
    chk($sformatf("cyc%0d.pass", i), 32'(ps), ep);
    chk($sformatf("cyc%0d.err_count", i), 32'(err), m_err[i]);
`ifdef FIRST_FAIL_CAPTURE_EN
    chk($sformatf("cyc%0d.fail_valid", i), 32'(fv), m_fv[i]);
    chk($sformatf("cyc%0d.fail_vec", i), 32'(fvec), m_fvec[i]);
`else
    if (fv !== 1'b0 || fvec !== 2'd0) $display("unexpected capture inputs");
`endif
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
`ifdef FIRST_FAIL_CAPTURE_EN
      check_inst(0, if_a.vec_out, if_a.vec_idx, if_a.busy, if_a.done, if_a.pass,
                 if_a.err_count, if_a.fail_valid, if_a.fail_vec);
      check_inst(1, if_b.vec_out, if_b.vec_idx, if_b.busy, if_b.done, if_b.pass,
                 if_b.err_count, if_b.fail_valid, if_b.fail_vec);
`else
      check_inst(0, if_a.vec_out, if_a.vec_idx, if_a.busy, if_a.done, if_a.pass,
                 if_a.err_count, 1'b0, 2'd0);
      check_inst(1, if_b.vec_out, if_b.vec_idx, if_b.busy, if_b.done, if_b.pass,
                 if_b.err_count, 1'b0, 2'd0);
`endif
    end
  end

  // ---------------- driver tasks ----------------
  task automatic pulse_start;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Counts edges after the start edge until each instance shows done.
  task automatic wait_done(input int c0, output int ca, output int cb);
    int cyc;
    cyc = c0; ca = -1; cb = -1;
    while ((ca < 0 || cb < 0) && cyc < 200) begin
      @(posedge clk);
      #1;
      cyc++;
      if (if_a.done && ca < 0) ca = cyc;
      if (if_b.done && cb < 0) cb = cyc;
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int ca, cb, n;
    rst = 1'b1; start = 1'b0; rnd_bit = 1'b0; mode = 0; chk_en = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_en = 1'b1;
    chk("reset.a.state", 32'(if_a.state), 0);
    chk("reset.a.done", 32'(if_a.done), 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(posedge clk);

    // 1: correct gates
    mode = 0;
    pulse_start();
    wait_done(0, ca, cb);
    chk("t1.a.done_cycle", ca, 16);
    chk("t1.b.done_cycle", cb, 12);
    chk("t1.a.pass", 32'(if_a.pass), 1);
    chk("t1.a.err_count", 32'(if_a.err_count), 0);
    chk("t1.b.pass", 32'(if_b.pass), 1);
    chk("t1.a.vec_hold", 32'(if_a.vec_out), 3);

    // 2: y tied 0
    mode = 1;
    pulse_start();
    wait_done(0, ca, cb);
    chk("t2.a.pass", 32'(if_a.pass), 0);
    chk("t2.a.err_count", 32'(if_a.err_count), 1);
    chk("t2.b.err_count", 32'(if_b.err_count), 2);
`ifdef FIRST_FAIL_CAPTURE_EN
    chk("t2.a.fail_vec", 32'(if_a.fail_vec), 3);
    chk("t2.b.fail_vec", 32'(if_b.fail_vec), 1);
`endif

    // 3: y tied 1
    mode = 2;
    pulse_start();
    wait_done(0, ca, cb);
    chk("t3.a.err_count", 32'(if_a.err_count), 3);
    chk("t3.a.pass", 32'(if_a.pass), 0);
    chk("t3.b.err_count", 32'(if_b.err_count), 2);
`ifdef FIRST_FAIL_CAPTURE_EN
    chk("t3.a.fail_valid", 32'(if_a.fail_valid), 1);
    chk("t3.a.fail_vec", 32'(if_a.fail_vec), 0);
`endif

    // 4: start re-pulsed at cycle 5 is ignored
    mode = 0;
    pulse_start();
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    pulse_start();
    wait_done(5, ca, cb);
    chk("t4.a.done_cycle", ca, 16);
    chk("t4.a.pass", 32'(if_a.pass), 1);
    chk("t4.a.err_count", 32'(if_a.err_count), 0);

    // 5: reset mid-run at vec_idx 2
    pulse_start();
    n = 0;
    while (if_a.vec_idx != 2'd2 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("t5.reach_idx2", 32'(if_a.vec_idx), 2);
    @(negedge clk);
    rst = 1'b1;
    start = 1'b1;              // rst must win over start
    @(posedge clk);
    #1;
    chk("t5.a.state", 32'(if_a.state), 0);
    chk("t5.a.vec_out", 32'(if_a.vec_out), 0);
    chk("t5.a.busy", 32'(if_a.busy), 0);
    chk("t5.a.err_count", 32'(if_a.err_count), 0);
    rst = 1'b0;
    start = 1'b0;
    pulse_start();
    wait_done(0, ca, cb);
    chk("t5.a.done_cycle", ca, 16);
    chk("t5.a.pass", 32'(if_a.pass), 1);

    // random gate output, random start pulses and occasional resets
    mode = 3;
    repeat (900) begin
      @(negedge clk);
      start   = ($urandom_range(7) == 0);
      rnd_bit = 1'($urandom_range(1));
      rst     = ($urandom_range(149) == 0);
    end
    @(negedge clk);
    start = 1'b0;
    rst = 1'b0;
    repeat (20) @(posedge clk);
    @(negedge clk);
    chk_en = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
